te_block_sequencer: RTL and testbench

Sits between `cva6_te_connector` and a single-port trace encoder. It accepts groups of up to N trace blocks per cycle and buffers each group as one entry. It then emits the blocks one at a time in ascending port order, under a valid/ready handshake. It also drives a stall back to the connector and counts overflows so that lost groups are visible.

---
 rtl/connector_pkg.sv | 36 +++
 rtl/fifo_v3.sv | 61 ++++++
 rtl/te_block_sequencer.sv | 175 +++++++++++++++++
 tb/tb_te_block_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/connector_pkg.sv
// connector_pkg: shared trace widths and block/group types used between
// cva6_te_connector and the single-port encoder sequencer.
package connector_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned CAUSE_LEN   = 5;
  localparam int unsigned PRIV_LEN    = 2;

  // Default number of ports per group; te_group_s is sized for it.
  localparam int unsigned NR_BLOCKS   = 2;

  // One trace block as seen by the encoder.
  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
  } te_block_s;

  // A compacted group of blocks plus the fields the group shares.
  typedef struct packed {
    te_block_s [NR_BLOCKS-1:0]    blocks;
    logic [$clog2(NR_BLOCKS):0]   count;
    logic [CAUSE_LEN-1:0]         cause;
    logic [XLEN-1:0]              tval;
    logic [PRIV_LEN-1:0]          priv;
  } te_group_s;

  // Exceptions (1) and interrupts (2) are the only types carrying cause/tval.
  function automatic logic is_trap_type(input logic [ITYPE_LEN-1:0] itype);
    return (itype == ITYPE_LEN'(1)) || (itype == ITYPE_LEN'(2));
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: first-word-fall-through FIFO of an arbitrary data type.
// A push while full is accepted when a pop happens in the same cycle.
// usage_o is one bit wider than the address so that "full" is representable.
module fifo_v3 #(
  parameter int unsigned DEPTH = 8,
  parameter type         dtype = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  dtype                     data_i,
  input  logic                     pop_i,
  output dtype                     data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  dtype            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; flush drops every stored entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, written at the tail; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/te_block_sequencer.sv
// te_block_sequencer: buffers multi-port trace groups and replays them one
// block per handshake to a single-port encoder.
// Optional feature macro: TE_SEQ_DROP_CNT_EN adds a saturating 16-bit
// dropped-group counter on drop_cnt_o.
module te_block_sequencer
  import connector_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [N-1:0]             valid_i,
  input  logic [N*IRETIRE_LEN-1:0] iretire_i,
  input  logic [N-1:0]             ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]   itype_i,
  input  logic [N*XLEN-1:0]        iaddr_i,
  input  logic [CAUSE_LEN-1:0]     cause_i,
  input  logic [XLEN-1:0]          tval_i,
  input  logic [PRIV_LEN-1:0]      priv_i,
  output logic                     stall_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [IRETIRE_LEN-1:0]   iretire_o,
  output logic                     ilastsize_o,
  output logic [ITYPE_LEN-1:0]     itype_o,
  output logic [XLEN-1:0]          iaddr_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic                     last_o,
  output logic                     overflow_o
`ifdef TE_SEQ_DROP_CNT_EN
 ,output logic [15:0]              drop_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(N) + 1;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  // Same layout as te_group_s, but sized by this instance's N.
  typedef struct packed {
    te_block_s [N-1:0]      blocks;
    logic [CNT_W-1:0]       count;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } group_t;

  group_t           in_group, head_group;
  te_block_s        cur_blk;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      usage;
  logic             any_valid, push, pop, drop, head_last, cur_trap;
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Compact the valid ports: the k-th set bit becomes block k of the entry.
  always_comb begin
    int rank;
    in_group = '0;
    rank     = 0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        for (int j = 0; j < N; j++) begin
          if (j == rank) begin
            in_group.blocks[j].iretire   = iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
            in_group.blocks[j].ilastsize = ilastsize_i[i];
            in_group.blocks[j].itype     = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
            in_group.blocks[j].iaddr     = iaddr_i[i*XLEN +: XLEN];
          end
        end
        rank = rank + 1;
      end
    end
    in_group.count = CNT_W'(rank);
    in_group.cause = cause_i;
    in_group.tval  = tval_i;
    in_group.priv  = priv_i;
  end

  assign any_valid = |valid_i;
  assign head_last = ((CNT_W'(idx_q) + CNT_W'(1)) == head_group.count);
  assign pop       = (state_q == EMIT) && ready_i && head_last;
  assign push      = any_valid && !flush_i && (!fifo_full || pop);
  assign drop      = any_valid && !flush_i && fifo_full && !pop;

  fifo_v3 #(
    .DEPTH (DEPTH),
    .dtype (group_t)
  ) i_group_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (in_group),
    .pop_i   (pop),
    .data_o  (head_group),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (usage)
  );

  // Head FSM next state: walk the head entry block by block, pop on its last.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (flush_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push || !fifo_empty) state_d = EMIT;
        end
        EMIT: begin
          if (ready_i) begin
            if (head_last) begin
              idx_d = '0;
              if ((usage == (AW+1)'(1)) && !push) state_d = IDLE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Head FSM state and block index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sticky loss flag; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   overflow_o <= 1'b0;
    else if (drop) overflow_o <= 1'b1;
  end

`ifdef TE_SEQ_DROP_CNT_EN
  // Saturating count of dropped groups, untouched by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              drop_cnt_o <= '0;
    else if (drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
  end
`endif

  // Data outputs are gated with valid_o so idle/reset shows all zeros.
  assign cur_blk     = head_group.blocks[idx_q];
  assign cur_trap    = is_trap_type(cur_blk.itype);
  assign valid_o     = (state_q == EMIT);
  assign iretire_o   = valid_o ? cur_blk.iretire   : '0;
  assign ilastsize_o = valid_o ? cur_blk.ilastsize : 1'b0;
  assign itype_o     = valid_o ? cur_blk.itype     : '0;
  assign iaddr_o     = valid_o ? cur_blk.iaddr     : '0;
  assign cause_o     = (valid_o && cur_trap) ? head_group.cause : '0;
  assign tval_o      = (valid_o && cur_trap) ? head_group.tval  : '0;
  assign priv_o      = valid_o ? head_group.priv   : '0;
  assign last_o      = valid_o && head_last;
  assign stall_o     = (usage >= (AW+1)'(DEPTH - 1));

endmodule

// File: tb/tb_te_block_sequencer.sv
// tb_te_block_sequencer: directed stimulus with a scoreboard queue; a
// separate monitor pops expected blocks on every output handshake.
module tb_te_block_sequencer;
  import connector_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 8;
  localparam logic [IRETIRE_LEN-1:0] IRET0 = 32'h0000_0011;
  localparam logic [IRETIRE_LEN-1:0] IRET1 = 32'h0000_0022;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic                   last;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush_i;
  logic [N-1:0]             valid_i;
  logic [N*IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]             ilastsize_i;
  logic [N*ITYPE_LEN-1:0]   itype_i;
  logic [N*XLEN-1:0]        iaddr_i;
  logic [CAUSE_LEN-1:0]     cause_i;
  logic [XLEN-1:0]          tval_i;
  logic [PRIV_LEN-1:0]      priv_i;
  logic                     stall_o, valid_o, ready_i;
  logic [IRETIRE_LEN-1:0]   iretire_o;
  logic                     ilastsize_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [XLEN-1:0]          iaddr_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;
  logic                     last_o, overflow_o;
`ifdef TE_SEQ_DROP_CNT_EN
  logic [15:0]              drop_cnt_o;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  te_block_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .iretire_i   (iretire_i),
    .ilastsize_i (ilastsize_i),
    .itype_i     (itype_i),
    .iaddr_i     (iaddr_i),
    .cause_i     (cause_i),
    .tval_i      (tval_i),
    .priv_i      (priv_i),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .iretire_o   (iretire_o),
    .ilastsize_o (ilastsize_o),
    .itype_o     (itype_o),
    .iaddr_o     (iaddr_o),
    .cause_o     (cause_o),
    .tval_o      (tval_o),
    .priv_o      (priv_o),
    .last_o      (last_o),
    .overflow_o  (overflow_o)
`ifdef TE_SEQ_DROP_CNT_EN
   ,.drop_cnt_o  (drop_cnt_o)
`endif
  );

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Drive one group for one cycle; expected blocks are queued if it should be emitted.
  task automatic applyStimulus(input logic [1:0] v, input logic [XLEN-1:0] a0,
                               input logic [XLEN-1:0] a1, input logic [2:0] t0,
                               input logic [2:0] t1, input logic [4:0] cs,
                               input logic [XLEN-1:0] tv, input logic [1:0] pv,
                               input bit fl, input bit accept);
    exp_t e;
    logic trap;
    valid_i = v;
    iaddr_i = {a1, a0};
    itype_i = {t1, t0};
    cause_i = cs;
    tval_i  = tv;
    priv_i  = pv;
    flush_i = fl;
    if (accept) begin
      for (int p = 0; p < 2; p++) begin
        if (v[p]) begin
          e.iretire   = (p == 0) ? IRET0 : IRET1;
          e.ilastsize = (p == 0);
          e.itype     = (p == 0) ? t0 : t1;
          e.iaddr     = (p == 0) ? a0 : a1;
          trap        = (e.itype == 3'd1) || (e.itype == 3'd2);
          e.cause     = trap ? cs : '0;
          e.tval      = trap ? tv : '0;
          e.priv      = pv;
          e.last      = (p == 1) || !v[1];
          sb.push_back(e);
        end
      end
    end
    @(posedge clk); #1;
    valid_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk);
    @(posedge clk); #1;
    checkOutput("drain_empty", 256'(sb.size()), 256'(0));
  endtask

  // Monitor: compare each handshaken block against the scoreboard head.
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_o && ready_i) begin
        act = {iretire_o, ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o, last_o};
        if (sb.size() == 0) begin
          checkOutput("unexpected_block", 256'(act), 256'(0));
          if (act == '0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_block: got zero block, want none");
          end
        end else begin
          e = sb.pop_front();
          checkOutput("block", 256'(act), 256'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    valid_i     = '0;
    iretire_i   = {IRET1, IRET0};
    ilastsize_i = 2'b01;
    itype_i     = '0;
    iaddr_i     = '0;
    cause_i     = '0;
    tval_i      = '0;
    priv_i      = '0;
    ready_i     = 1'b0;
    #2;
    checkOutput("reset_valid",    256'(valid_o),    256'(0));
    checkOutput("reset_stall",    256'(stall_o),    256'(0));
    checkOutput("reset_overflow", 256'(overflow_o), 256'(0));
    checkOutput("reset_last",     256'(last_o),     256'(0));
    checkOutput("reset_iaddr",    256'(iaddr_o),    256'(0));
`ifdef TE_SEQ_DROP_CNT_EN
    checkOutput("reset_drop_cnt", 256'(drop_cnt_o), 256'(0));
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single block");
    ready_i = 1'b1;
    applyStimulus(2'b01, 64'h8000_0000, 64'h0, 3'd0, 3'd0, 5'd0, 64'h0, 2'd3, 1'b0, 1'b1);
    checkOutput("latency_valid", 256'(valid_o), 256'(1));
    checkOutput("latency_last",  256'(last_o),  256'(1));
    waitDrain();

    $display("[TB] compaction");
    applyStimulus(2'b10, 64'h0, 64'h1000, 3'd0, 3'd0, 5'd0, 64'h0, 2'd1, 1'b0, 1'b1);
    applyStimulus(2'b11, 64'h2000, 64'h3000, 3'd0, 3'd0, 5'd0, 64'h0, 2'd1, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] trap group");
    applyStimulus(2'b11, 64'hA000, 64'hA004, 3'd1, 3'd4, 5'h2, 64'hDEAD, 2'd3, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] backpressure");
    ready_i = 1'b0;
    applyStimulus(2'b01, 64'h4444, 64'h0, 3'd0, 3'd0, 5'd0, 64'h0, 2'd0, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checkOutput("hold_valid", 256'(valid_o), 256'(1));
      checkOutput("hold_iaddr", 256'(iaddr_o), 256'(64'h4444));
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    checkOutput("advance_valid", 256'(valid_o), 256'(0));
    waitDrain();

    $display("[TB] fill and overflow");
    ready_i = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      applyStimulus(2'b01, 64'h100 + 64'(k - 1), 64'h0, 3'd0, 3'd0, 5'd0, 64'h0, 2'd0,
                    1'b0, k <= DEPTH);
      checkOutput("stall_fill", 256'(stall_o), 256'(k >= DEPTH - 1));
      if (k == DEPTH) checkOutput("overflow_before", 256'(overflow_o), 256'(0));
    end
    checkOutput("overflow_set", 256'(overflow_o), 256'(1));
`ifdef TE_SEQ_DROP_CNT_EN
    checkOutput("drop_cnt_one", 256'(drop_cnt_o), 256'(1));
`endif
    ready_i = 1'b1;
    applyStimulus(2'b01, 64'h999, 64'h0, 3'd0, 3'd0, 5'd0, 64'h0, 2'd2, 1'b0, 1'b1);
    checkOutput("stall_full_swap", 256'(stall_o), 256'(1));
`ifdef TE_SEQ_DROP_CNT_EN
    checkOutput("drop_cnt_swap", 256'(drop_cnt_o), 256'(1));
`endif
    waitDrain();

    $display("[TB] flush mid-group");
    ready_i = 1'b0;
    applyStimulus(2'b11, 64'h6000, 64'h6001, 3'd0, 3'd0, 5'd0, 64'h0, 2'd0, 1'b0, 1'b0);
    checkOutput("pre_flush_iaddr", 256'(iaddr_o), 256'(64'h6000));
    checkOutput("pre_flush_last",  256'(last_o),  256'(0));
    applyStimulus(2'b11, 64'h7000, 64'h7001, 3'd0, 3'd0, 5'd0, 64'h0, 2'd0, 1'b1, 1'b0);
    checkOutput("flush_valid",    256'(valid_o),    256'(0));
    checkOutput("flush_stall",    256'(stall_o),    256'(0));
    checkOutput("flush_overflow", 256'(overflow_o), 256'(1));
    ready_i = 1'b1;
    applyStimulus(2'b01, 64'h5555, 64'h0, 3'd0, 3'd0, 5'd0, 64'h0, 2'd1, 1'b0, 1'b1);
    checkOutput("post_flush_valid", 256'(valid_o), 256'(1));
    checkOutput("post_flush_last",  256'(last_o),  256'(1));
    waitDrain();

    $display("[TB] async reset mid-group");
    ready_i = 1'b0;
    applyStimulus(2'b11, 64'hB000, 64'hB004, 3'd0, 3'd0, 5'd0, 64'h0, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid",    256'(valid_o),    256'(0));
    checkOutput("areset_overflow", 256'(overflow_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("scoreboard_empty", 256'(sb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
